stop_request_encoder: RTL and testbench
=======================================

// Module: stop_request_encoder
// PURPOSE
//  Source-domain stage feeding the interruption manager's mux synchronizer.
//  Accepts three level stop requests and encodes each new combination into the 3-bit interruption code.
//  Publishes the code with a qualifier that meets mux-sync rules: code stable before, during and after valid.
//  Coalesces requests that change mid-transfer; only the latest combination is sent next.
// PARAMETERS
//  HOLD_CYCLES    3  cycles o_valid stays high per transfer (>=1)
//  GAP_CYCLES     2  cycles o_code is held after o_valid falls, before a new transfer may start (>=1)
//  FILTER_CYCLES  4  cycles req_stop must be stable to be accepted (used only with STOP_REQ_FILTER_EN, >=1)
// PORTS
//  clk           in   1  source-domain clock
//  rst_n         in   1  asynchronous active-low reset
//  req_stop      in   3  requested stops: [2]=stop1 [1]=stop2 [0]=stop3, level
//  o_code        out  3  interruption code to mux synchronizer data input
//  o_valid       out  1  code qualifier to mux synchronizer valid input
//  o_busy        out  1  high in PUBLISH or GAP
//  o_coalesce    out  8  saturating count of request changes absorbed while busy
// BEHAVIOUR
//  Reset (async assert, sync release): o_code=0, o_valid=0, o_busy=0, o_coalesce=0, last_sent=3'b000, state=IDLE.
//  Encoding {stop1,stop2,stop3} -> code:
//   000->0  010->1  001->2  110->3  101->4  011->5  100->6  111->7.
//  req_eff = req_stop registered once (1-cycle input flop); with filter see CONFIGURATION.
//  FSM states IDLE, PUBLISH, GAP:
//   IDLE: if req_eff != last_sent -> next edge: o_code=enc(req_eff), o_valid=1, last_sent=req_eff, PUBLISH.
//         else stay; o_code keeps last value, o_valid=0.
//   PUBLISH: o_valid held 1 for exactly HOLD_CYCLES cycles, o_code constant -> GAP.
//   GAP: o_valid=0, o_code constant for exactly GAP_CYCLES cycles -> IDLE.
//  Latency: req_stop change to o_valid rise = 2 cycles from IDLE (input flop + FSM).
//  Min spacing between o_valid rises = HOLD_CYCLES+GAP_CYCLES+1 cycles (one IDLE compare cycle).
//  o_code changes only on the IDLE->PUBLISH edge; never while o_valid=1 or in GAP.
//  Changes of req_eff while busy: no effect on the transfer in flight; IDLE compares against
//   the latest req_eff, so intermediate values are dropped; o_coalesce +1 per cycle where
//   req_eff differs from its previous-cycle value while o_busy=1; saturates at 255.
//  Request returning to last_sent before IDLE: no transfer issued (still counted in o_coalesce).
//  Code 0 (all stops released) is a normal transfer when last_sent != 000.
//  Reset mid-PUBLISH/GAP: outputs drop to reset values immediately; last_sent=000 so a held
//   nonzero request republishes after release.
//  o_busy = (state != IDLE), registered.
// CONFIGURATION
//  STOP_REQ_FILTER_EN defined: req_eff updates only after the registered req_stop has held one
//   value for FILTER_CYCLES consecutive cycles; glitches shorter than that are ignored; latency
//   becomes FILTER_CYCLES+2 cycles. Filter counter and req_eff reset to 0.
//  STOP_REQ_FILTER_EN undefined: no filter logic; req_eff = one-flop registered req_stop.
// TESTING
//  Reset, req_stop=000 held 20 cycles -> o_valid never rises, o_code=0, o_coalesce=0.
//  req_stop 000->110 at cycle t -> o_valid=1 cycles t+2..t+4, o_code=3 from t+2 to next transfer.
//  req_stop 110->011->101 while busy -> one next transfer with o_code=4, o_coalesce=2.
//  req_stop 000->001->000 within PUBLISH of a prior code-0 transfer -> no new transfer.
//  rst_n low during PUBLISH with req_stop=111 held -> o_valid=0 at once; after release code 7 sent.
//  Filter on, 2-cycle pulse 100 then stable 100 for 4 cycles -> one transfer, o_code=6, after the stable run.

Source files
------------

// File: rtl/stop_request_encoder.sv
// -----------------------------------------------------------------------------
// stop_request_encoder
//
// Source-domain stage in front of the interruption manager's mux synchronizer.
// Three level stop requests are registered, optionally debounced, and every
// new combination is encoded into a 3-bit interruption code.
//
// The code is published with a qualifier that obeys mux-sync rules. o_code is
// loaded only when a transfer starts. It then stays constant while o_valid is
// high (HOLD_CYCLES) and for GAP_CYCLES afterwards. Request changes that arrive
// mid-transfer are coalesced: only the latest combination is sent next.
//
// Parameters
//   HOLD_CYCLES    cycles o_valid stays high per transfer (>=1)
//   GAP_CYCLES     cycles o_code is held after o_valid falls (>=1)
//   FILTER_CYCLES  stability window for req_stop (>=1). It exists only when
//                  STOP_REQ_FILTER_EN is defined.
//
// Configuration macro
//   STOP_REQ_FILTER_EN  when defined, the registered request must hold one
//                       value for FILTER_CYCLES consecutive cycles before it
//                       is acted on. When undefined, the one-flop registered
//                       request is used directly.
//
// Ports
//   clk         in   1  source-domain clock
//   rst_n       in   1  asynchronous active-low reset, synchronous release
//   req_stop    in   3  [2]=stop1 [1]=stop2 [0]=stop3, level requests
//   o_code      out  3  interruption code to the mux synchronizer data input
//   o_valid     out  1  code qualifier to the mux synchronizer valid input
//   o_busy      out  1  high while a transfer is publishing or in its gap
//   o_coalesce  out  8  saturating count of request changes absorbed while busy
// -----------------------------------------------------------------------------
module stop_request_encoder #(
  parameter int HOLD_CYCLES   = 3,
  parameter int GAP_CYCLES    = 2
`ifdef STOP_REQ_FILTER_EN
  ,
  parameter int FILTER_CYCLES = 4
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req_stop,
  output logic [2:0] o_code,
  output logic       o_valid,
  output logic       o_busy,
  output logic [7:0] o_coalesce
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PUBLISH = 2'd1,
    GAP     = 2'd2
  } state_t;

  // One counter serves both timed phases, so it is sized for the longer one.
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  // {stop1,stop2,stop3} -> interruption code. This is not a binary weighting,
  // so a table is the clearest form.
  function automatic logic [2:0] encode_stops(input logic [2:0] stops);
    logic [2:0] code;
    case (stops)
      3'b000:  code = 3'd0;
      3'b010:  code = 3'd1;
      3'b001:  code = 3'd2;
      3'b110:  code = 3'd3;
      3'b101:  code = 3'd4;
      3'b011:  code = 3'd5;
      3'b100:  code = 3'd6;
      default: code = 3'd7;   // 3'b111
    endcase
    return code;
  endfunction

  // ---------------------------------------------------------------------------
  // Input stage: one flop on the raw request, plus an optional stability filter
  // ---------------------------------------------------------------------------
  logic [2:0] req_q;
  logic [2:0] req_eff;

  // NOTE: every register in this block is small control state, so all of it
  // is reset. Nothing here is a memory array that could be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= 3'b000;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples pre-edge values regardless of statement order.
      req_q <= req_stop;
    end
  end

`ifdef STOP_REQ_FILTER_EN
  localparam int FLT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [FLT_W-1:0] FLT_FULL = FLT_W'(FILTER_CYCLES);

  // flt_cnt = number of consecutive cycles req_q has held its current value.
  // It saturates at FILTER_CYCLES.
  logic [FLT_W-1:0] flt_cnt;
  logic [2:0]       req_filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_cnt  <= '0;
      req_filt <= 3'b000;
    end else begin
      if (req_stop != req_q) begin
        flt_cnt <= FLT_W'(1);
      end else if (flt_cnt != FLT_FULL) begin
        flt_cnt <= flt_cnt + FLT_W'(1);
      end
      if (flt_cnt == FLT_FULL) begin
        req_filt <= req_q;
      end
    end
  end

  assign req_eff = req_filt;
`else
  assign req_eff = req_q;
`endif

  // ---------------------------------------------------------------------------
  // Transfer FSM: IDLE compares, PUBLISH drives valid, GAP holds the code
  // ---------------------------------------------------------------------------
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       last_sent, last_sent_nxt;
  logic [2:0]       code_nxt;
  logic             valid_nxt;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_nxt     = state;
    cnt_nxt       = cnt;
    last_sent_nxt = last_sent;
    code_nxt      = o_code;
    valid_nxt     = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        // The comparison always uses the latest req_eff. Anything that came and
        // went during the previous transfer is silently dropped here.
        if (req_eff != last_sent) begin
          state_nxt     = PUBLISH;
          code_nxt      = encode_stops(req_eff);
          last_sent_nxt = req_eff;
          valid_nxt     = 1'b1;
        end
      end
      PUBLISH: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
          valid_nxt = 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // All outputs are registered from next-state values. This keeps them
  // glitch-free toward the synchronizer, and o_busy lines up exactly with the
  // PUBLISH/GAP cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last_sent <= 3'b000;
      o_code    <= 3'd0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      last_sent <= last_sent_nxt;
      o_code    <= code_nxt;
      o_valid   <= valid_nxt;
      o_busy    <= (state_nxt != IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Coalesce counter: request changes seen while a transfer is in flight
  // ---------------------------------------------------------------------------
  logic [2:0] req_eff_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_eff_prev <= 3'b000;
      o_coalesce   <= 8'd0;
    end else begin
      req_eff_prev <= req_eff;
      if (o_busy && (req_eff != req_eff_prev) && (o_coalesce != 8'hFF)) begin
        o_coalesce <= o_coalesce + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_stop_request_encoder.sv
// -----------------------------------------------------------------------------
// tb_stop_request_encoder
//
// Self-checking bench for stop_request_encoder.
//
// A transaction-level model predicts every output on every cycle. It tracks
// the remaining busy time of a transfer as one countdown and derives
// valid/busy from it arithmetically. Directed scenarios pin the model with
// hand-computed literal expectations. A randomized phase follows, with
// occasional resets.
// -----------------------------------------------------------------------------
module tb_stop_request_encoder;

  localparam int HOLD = 3;
  localparam int GAP  = 2;
`ifdef STOP_REQ_FILTER_EN
  localparam int FILT = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req_stop = 3'b000;
  logic [2:0] o_code;
  logic       o_valid;
  logic       o_busy;
  logic [7:0] o_coalesce;

  always #5 clk = ~clk;

  stop_request_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_stop   (req_stop),
    .o_code     (o_code),
    .o_valid    (o_valid),
    .o_busy     (o_busy),
    .o_coalesce (o_coalesce)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [2:0] raw;        // request after the input flop
    logic [2:0] eff;        // request the transfer logic acts on
    logic [2:0] eff_prev;   // eff one cycle earlier
    logic [2:0] last;       // combination most recently sent
    logic [2:0] code;       // published code
    int         busy_left;  // cycles of the current transfer still to come
    int         coal;       // absorbed-change count
    int         stable;     // consecutive cycles raw has held its value
  } model_t;

  model_t m;

  function automatic logic [2:0] enc(input logic [2:0] s);
    case (s)
      3'b000: return 3'd0;
      3'b010: return 3'd1;
      3'b001: return 3'd2;
      3'b110: return 3'd3;
      3'b101: return 3'd4;
      3'b011: return 3'd5;
      3'b100: return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r.raw = 3'b000; r.eff = 3'b000; r.eff_prev = 3'b000; r.last = 3'b000;
    r.code = 3'd0; r.busy_left = 0; r.coal = 0; r.stable = 0;
    return r;
  endfunction

  // One clock edge of the model. A transfer occupies HOLD+GAP cycles:
  // valid is high while more than GAP cycles remain.
  function automatic model_t model_step(input model_t c, input logic [2:0] req);
    model_t n;
    n = c;
    if (c.busy_left > 0 && c.eff != c.eff_prev && c.coal < 255) n.coal = c.coal + 1;
    n.eff_prev = c.eff;
    if (c.busy_left > 0) begin
      n.busy_left = c.busy_left - 1;
    end else if (c.eff != c.last) begin
      n.code      = enc(c.eff);
      n.last      = c.eff;
      n.busy_left = HOLD + GAP;
    end
`ifdef STOP_REQ_FILTER_EN
    if (c.stable >= FILT) n.eff = c.raw;
    n.stable = (req != c.raw) ? 1 : ((c.stable + 1 > FILT) ? FILT : c.stable + 1);
    n.raw    = req;
`else
    n.raw = req;
    n.eff = req;
`endif
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_step(m, req_stop);
  end

  // Compare process: every cycle, away from the active edge.
  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_code",     o_code,     m.code);
      check("cyc_valid",    o_valid,    m.busy_left > GAP);
      check("cyc_busy",     o_busy,     m.busy_left > 0);
      check("cyc_coalesce", o_coalesce, m.coal);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after a rising edge
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    logic [2:0] r;

    req_stop = 3'b000;
    do_reset();
    cmp_en = 1'b1;

    // Idle with no request: nothing is ever published.
    check("rst_code", o_code, 0);
    check("rst_busy", o_busy, 0);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("idle_valid", o_valid, 0);
    end
    check("idle_code", o_code, 0);
    check("idle_coalesce", o_coalesce, 0);

`ifndef STOP_REQ_FILTER_EN
    // 000 -> 110 in cycle t: valid in t+2..t+4, code 3 held through the gap.
    req_stop = 3'b110;
    tick(1); check("s2_t1_valid", o_valid, 0);
    tick(1); check("s2_t2_valid", o_valid, 1); check("s2_t2_code", o_code, 3);
    tick(2); check("s2_t4_valid", o_valid, 1);
    tick(1); check("s2_t5_valid", o_valid, 0); check("s2_t5_busy", o_busy, 1);
             check("s2_t5_code", o_code, 3);
    tick(2); check("s2_t7_busy", o_busy, 0); check("s2_t7_code", o_code, 3);

    // 110 -> 011 -> 101 while busy: one follow-up transfer with code 4.
    do_reset();
    req_stop = 3'b110;
    tick(2); req_stop = 3'b011;
    tick(1); req_stop = 3'b101;
    tick(4); check("s3_t7_valid", o_valid, 0); check("s3_t7_code", o_code, 3);
    tick(1); check("s3_t8_valid", o_valid, 1); check("s3_t8_code", o_code, 4);
             check("s3_coalesce", o_coalesce, 2);
    tick(5);

    // Code-0 transfer, then 001 -> 000 inside its publish window: no new transfer.
    req_stop = 3'b000;
    tick(2); check("s4_code0_valid", o_valid, 1); check("s4_code0", o_code, 0);
    req_stop = 3'b001;
    tick(1); req_stop = 3'b000;
    tick(2);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("s4_no_xfer", o_valid, 0);
    end
    check("s4_coalesce", o_coalesce, 4);

    // Reset in the middle of PUBLISH with 111 held, then code 7 republished.
    req_stop = 3'b111;
    tick(3); check("s5_pre_valid", o_valid, 1);
    rst_n = 1'b0;
    #1;
    check("s5_rst_valid", o_valid, 0);
    check("s5_rst_code", o_code, 0);
    check("s5_rst_busy", o_busy, 0);
    tick(2);
    rst_n = 1'b1;
    k = 0;
    while (!o_valid && k < 10) begin
      tick(1);
      k++;
    end
    check("s5_republish_lat", k, 2);
    check("s5_republish_code", o_code, 7);

    // Request changing every cycle: the coalesce count saturates at 255.
    for (int i = 0; i < 600; i++) begin
      do r = 3'($urandom_range(0, 7)); while (r == req_stop);
      req_stop = r;
      tick(1);
    end
    tick(2);
    check("s6_saturate", o_coalesce, 255);
`else
    // Short 100 pulse is filtered. A stable 100 run sends code 6 after FILT+2.
    req_stop = 3'b100;
    tick(2); req_stop = 3'b000;
    tick(2); req_stop = 3'b100;
    k = 0;
    while (!o_valid && k < 20) begin
      tick(1);
      k++;
    end
    check("flt_latency", k, FILT + 2);
    check("flt_code", o_code, 6);
    tick(8);
`endif

    // Randomized phase: random values held for random lengths, rare resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        req_stop = 3'($urandom_range(0, 7));
        tick($urandom_range(1, 8));
      end
    end

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
